// File: rtl/arb_pkg.sv
// Shared types and sizing for the CPU/DMA bus arbiter.
package arb_pkg;

  localparam int unsigned ADDR_W            = 16;
  localparam int unsigned DATA_W            = 8;
  localparam int unsigned BURST_CNT_W       = 4;
  localparam int unsigned MAX_BURST_DEFAULT = 4;

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } arb_state_e;

  // One bus cycle request as presented to memory.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/cpu_dma_arbiter.sv
// Shares the 65CE02 memory bus between the core and one DMA requester.
// Optional ARB_SYNC_ONLY_EN: DMA bursts may only start on an opcode fetch.
module cpu_dma_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_address_next,
  input  logic              cpu_write_next,
  input  logic [DATA_W-1:0] cpu_data_o_next,
  input  logic              cpu_sync,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_data_i,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              dma_owner
);

  arb_state_e             state_q, state_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q;
  logic [DATA_W-1:0]      hold_q;
  bus_req_t               bus_q;
  bus_req_t               cpu_bus, dma_bus;
  logic                   sync_ok;
  logic                   eligible;
  logic                   take_dma;

  assign cpu_bus = '{addr: cpu_address_next, we: cpu_write_next, wdata: cpu_data_o_next};
  assign dma_bus = '{addr: dma_addr, we: dma_we, wdata: dma_wdata};

`ifdef ARB_SYNC_ONLY_EN
  // A new burst only begins at an instruction boundary; continuing one needs no sync.
  assign sync_ok = (state_q == S_DMA) | cpu_sync;
`else
  logic unused_sync;
  assign unused_sync = cpu_sync;
  assign sync_ok     = 1'b1;
`endif

  assign eligible  = dma_req & (burst_cnt_q != BURST_CNT_W'(MAX_BURST)) & sync_ok;
  assign take_dma  = reset_n & mem_ready & eligible;
  assign cpu_ready = mem_ready & ~take_dma;

  // Data-phase owner state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_CPU;
    else          state_q <= state_d;
  end

  // Next owner and owner-derived outputs.
  always_comb begin
    state_d    = state_q;
    dma_owner  = 1'b0;
    dma_ack    = 1'b0;
    cpu_data_i = hold_q;
    if (mem_ready) state_d = take_dma ? S_DMA : S_CPU;
    case (state_q)
      S_DMA: begin
        dma_owner = 1'b1;
        dma_ack   = mem_ready;
      end
      default: cpu_data_i = mem_rdata;
    endcase
  end

  assign dma_rdata = mem_rdata;

  // Bus capture, burst counter and CPU read-data hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_q       <= '0;
      burst_cnt_q <= '0;
      hold_q      <= '0;
    end else if (mem_ready) begin
      bus_q       <= take_dma ? dma_bus : cpu_bus;
      // A CPU capture resets the run; the compare in eligible stops the count at MAX_BURST.
      burst_cnt_q <= take_dma ? burst_cnt_q + BURST_CNT_W'(1) : '0;
      if (state_q == S_CPU) hold_q <= mem_rdata;
    end
  end

  assign mem_addr  = bus_q.addr;
  assign mem_we    = bus_q.we;
  assign mem_wdata = bus_q.wdata;

endmodule

// File: tb/tb_cpu_dma_arbiter.sv
// Directed table-driven bench for cpu_dma_arbiter (MAX_BURST = 4).
module tb_cpu_dma_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_address_next;
  logic        cpu_write_next;
  logic [7:0]  cpu_data_o_next;
  logic        cpu_sync;
  logic        cpu_ready;
  logic [7:0]  cpu_data_i;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        dma_we;
  logic [7:0]  dma_wdata;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        dma_owner;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_dma_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_address_next(cpu_address_next), .cpu_write_next(cpu_write_next),
    .cpu_data_o_next(cpu_data_o_next), .cpu_sync(cpu_sync),
    .cpu_ready(cpu_ready), .cpu_data_i(cpu_data_i),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .dma_owner(dma_owner)
  );

  typedef struct {
    logic [15:0] ca; logic cw; logic [7:0] cd;
    logic dreq; logic [15:0] da; logic dw; logic [7:0] dd;
    logic [7:0] rd;
    logic e_rdy; logic [7:0] e_di; logic e_ack; logic e_own;
    logic [15:0] e_ma; logic e_mw; logic [7:0] e_md; logic [7:0] e_drd;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [15:0] ca, input logic cw, input logic [7:0] cd,
    input logic dreq, input logic [15:0] da, input logic dw, input logic [7:0] dd,
    input logic [7:0] rd,
    input logic e_rdy, input logic [7:0] e_di, input logic e_ack, input logic e_own,
    input logic [15:0] e_ma, input logic e_mw, input logic [7:0] e_md);
    vec_t v;
    v.ca = ca; v.cw = cw; v.cd = cd; v.dreq = dreq; v.da = da; v.dw = dw; v.dd = dd;
    v.rd = rd; v.e_rdy = e_rdy; v.e_di = e_di; v.e_ack = e_ack; v.e_own = e_own;
    v.e_ma = e_ma; v.e_mw = e_mw; v.e_md = e_md; v.e_drd = rd;
    return v;
  endfunction

  task automatic apply(input int idx, input vec_t v);
    string t;
    @(negedge clk);
    cpu_address_next = v.ca; cpu_write_next = v.cw; cpu_data_o_next = v.cd;
    dma_req = v.dreq; dma_addr = v.da; dma_we = v.dw; dma_wdata = v.dd;
    mem_rdata = v.rd; mem_ready = 1'b1; cpu_sync = 1'b1;
    #1;
    t = $sformatf("v%0d", idx);
    chk({t, ".cpu_ready"},  16'(cpu_ready),  16'(v.e_rdy));
    chk({t, ".cpu_data_i"}, 16'(cpu_data_i), 16'(v.e_di));
    chk({t, ".dma_ack"},    16'(dma_ack),    16'(v.e_ack));
    chk({t, ".dma_owner"},  16'(dma_owner),  16'(v.e_own));
    chk({t, ".mem_addr"},   mem_addr,        v.e_ma);
    chk({t, ".mem_we"},     16'(mem_we),     16'(v.e_mw));
    chk({t, ".mem_wdata"},  16'(mem_wdata),  16'(v.e_md));
    chk({t, ".dma_rdata"},  16'(dma_rdata),  16'(v.e_drd));
  endtask

  initial begin
    //            ca      cw  cd     rq  da       dw  dd     rd     rdy di     ack own ma       mw  md
    vecs[0] = mk(16'h1234,0,8'h00, 0,16'h0000,0,8'h00, 8'h00, 1,8'h00, 0,0,16'h0000,0,8'h00);
    vecs[1] = mk(16'h1235,0,8'h00, 0,16'h0000,0,8'h00, 8'h5A, 1,8'h5A, 0,0,16'h1234,0,8'h00);
    vecs[2] = mk(16'h1236,0,8'h00, 1,16'h8000,1,8'hC3, 8'h77, 0,8'h77, 0,0,16'h1235,0,8'h00);
    vecs[3] = mk(16'h1236,0,8'h00, 0,16'h8000,1,8'hC3, 8'h99, 1,8'h77, 1,1,16'h8000,1,8'hC3);
    vecs[4] = mk(16'h1237,0,8'h00, 0,16'h0000,0,8'h00, 8'h44, 1,8'h44, 0,0,16'h1236,0,8'h00);
    vecs[5] = mk(16'h2000,1,8'hAB, 1,16'h9000,0,8'h00, 8'h11, 0,8'h11, 0,0,16'h1237,0,8'h00);
    vecs[6] = mk(16'h2000,1,8'hAB, 0,16'h9000,0,8'h00, 8'hE5, 1,8'h11, 1,1,16'h9000,0,8'h00);
    vecs[7] = mk(16'h2001,0,8'h00, 0,16'h0000,0,8'h00, 8'h00, 1,8'h00, 0,0,16'h2000,1,8'hAB);

    // Reset held with a pending DMA request
    reset_n = 1'b0; mem_ready = 1'b1; dma_req = 1'b1; dma_addr = 16'hFFFF;
    dma_we = 1'b1; dma_wdata = 8'hEE; cpu_address_next = 16'h0000;
    cpu_write_next = 1'b0; cpu_data_o_next = 8'h00; cpu_sync = 1'b1; mem_rdata = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.mem_addr",  mem_addr,          16'h0000);
    chk("rst.mem_we",    16'(mem_we),       16'h0);
    chk("rst.cpu_ready", 16'(cpu_ready),    16'h1);
    chk("rst.dma_ack",   16'(dma_ack),      16'h0);
    chk("rst.dma_owner", 16'(dma_owner),    16'h0);
    dma_req = 1'b0;
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) apply(i, vecs[i]);

    // Burst fairness: D D D D C D D D D C
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      dma_req = 1'b1; dma_addr = 16'hA000 + 16'(k); dma_we = 1'b0;
      cpu_address_next = 16'h3000; cpu_write_next = 1'b0; cpu_sync = 1'b1;
      mem_ready = 1'b1; mem_rdata = 8'(k);
      #1;
      chk($sformatf("burst%0d.cpu_ready", k), 16'(cpu_ready), 16'((k == 4) || (k == 9)));
      @(posedge clk); #1;
      chk($sformatf("burst%0d.dma_owner", k), 16'(dma_owner), 16'(!((k == 4) || (k == 9))));
      chk($sformatf("burst%0d.mem_addr", k), mem_addr,
          ((k == 4) || (k == 9)) ? 16'h3000 : 16'hA000 + 16'(k));
    end
    @(negedge clk); dma_req = 1'b0;

    // Wait states during a DMA data phase
    @(negedge clk);
    dma_req = 1'b1; dma_addr = 16'hB000; mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("ws.owner", 16'(dma_owner), 16'h1);
    for (int w = 0; w < 3; w++) begin
      @(negedge clk); mem_ready = 1'b0; #1;
      chk($sformatf("ws%0d.mem_addr", w),  mem_addr,        16'hB000);
      chk($sformatf("ws%0d.dma_ack", w),   16'(dma_ack),    16'h0);
      chk($sformatf("ws%0d.cpu_ready", w), 16'(cpu_ready),  16'h0);
    end
    @(negedge clk); mem_ready = 1'b1; dma_req = 1'b0; #1;
    chk("ws.ack_return", 16'(dma_ack),   16'h1);
    chk("ws.cpu_ready",  16'(cpu_ready), 16'h1);
    @(posedge clk); #1;
    chk("ws.back_to_cpu", mem_addr, 16'h3000);

    // Reset mid-burst abandons the in-flight DMA cycle
    @(negedge clk); dma_req = 1'b1; dma_addr = 16'hC100;
    @(posedge clk); #2;
    chk("mid.owner_pre", 16'(dma_owner), 16'h1);
    reset_n = 1'b0; #1;
    chk("mid.dma_ack",   16'(dma_ack),   16'h0);
    chk("mid.dma_owner", 16'(dma_owner), 16'h0);
    chk("mid.mem_addr",  mem_addr,       16'h0000);
    chk("mid.cpu_ready", 16'(cpu_ready), 16'h1);
    @(negedge clk); dma_req = 1'b0; reset_n = 1'b1;

    // Burst start relative to cpu_sync
    cpu_address_next = 16'hC000; dma_addr = 16'hD000;
`ifdef ARB_SYNC_ONLY_EN
    for (int s = 0; s < 5; s++) begin
      @(negedge clk); dma_req = 1'b1; cpu_sync = 1'b0; #1;
      chk($sformatf("sync%0d.cpu_ready", s), 16'(cpu_ready), 16'h1);
      @(posedge clk); #1;
      chk($sformatf("sync%0d.owner", s), 16'(dma_owner), 16'h0);
    end
    @(negedge clk); cpu_sync = 1'b1; #1;
`else
    @(negedge clk); dma_req = 1'b1; cpu_sync = 1'b0; #1;
`endif
    chk("sync.cpu_ready", 16'(cpu_ready), 16'h0);
    @(posedge clk); #1;
    chk("sync.owner",    16'(dma_owner), 16'h1);
    chk("sync.mem_addr", mem_addr,       16'hD000);
    @(negedge clk); dma_req = 1'b0;
    @(posedge clk); #1;
    chk("sync.fetch_after", mem_addr,       16'hC000);
    chk("sync.owner_after", 16'(dma_owner), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
